// File: rtl/tx_sequence_bits_emitter.sv
// Serial chip emitter: streams one bit column of the 16x256 sequence memory, holding each chip CHIP_CYCLES clocks.
// Optional macro TX_RESTART_EN: a trigger while busy aborts and restarts with the new sequence.
module tx_sequence_bits_emitter #(
    parameter int unsigned SEQ_LEN     = 255,
    parameter int unsigned CHIP_CYCLES = 2,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic              ctx_clk,
    input  logic              rtx_rst,
    input  logic              etx_en,
    input  logic              istart_trig,
    input  logic [3:0]        isequence_sel,
    output logic              omem_rd_en,
    output logic [ADDR_W-1:0] omem_addr,
    input  logic [15:0]       imem_data,
    output logic              otx_bit,
    output logic              otx_valid,
    output logic              obusy,
    output logic              odone
);

    localparam int unsigned HOLD_W = (CHIP_CYCLES > 1) ? $clog2(CHIP_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] CHIP_LAST = ADDR_W'(SEQ_LEN - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CHIP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, PREFETCH, LOAD, EMIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        seqSel_q, seqSel_d;
    logic [ADDR_W-1:0] chipCnt_q, chipCnt_d;
    logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic              txBit_q, txBit_d;

    // Read address for the next chip, pinned at the last chip so the port never leaves the sequence.
    function automatic logic [ADDR_W-1:0] satAddr(input logic [ADDR_W:0] a);
        if (a >= {1'b0, CHIP_LAST}) begin
            return CHIP_LAST;
        end
        return a[ADDR_W-1:0];
    endfunction

    always_ff @(posedge ctx_clk) begin
        if (rtx_rst) begin
            state_q   <= IDLE;
            seqSel_q  <= '0;
            chipCnt_q <= '0;
            holdCnt_q <= '0;
            memAddr_q <= '0;
            txBit_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            seqSel_q  <= seqSel_d;
            chipCnt_q <= chipCnt_d;
            holdCnt_q <= holdCnt_d;
            memAddr_q <= memAddr_d;
            txBit_q   <= txBit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        seqSel_d  = seqSel_q;
        chipCnt_d = chipCnt_q;
        holdCnt_d = holdCnt_q;
        memAddr_d = memAddr_q;
        txBit_d   = txBit_q;

        case (state_q)
            IDLE, DONE: begin
                chipCnt_d = '0;
                holdCnt_d = '0;
                memAddr_d = '0;
                txBit_d   = 1'b0;
                state_d   = IDLE;
                if (istart_trig) begin
                    state_d  = PREFETCH;
                    seqSel_d = isequence_sel;
                end
            end
            PREFETCH: state_d = LOAD;
            LOAD: begin
                // Word 0 arrives now; chip 1 is requested as chip 0 starts.
                txBit_d   = imem_data[seqSel_q];
                memAddr_d = satAddr((ADDR_W + 1)'(1));
                chipCnt_d = '0;
                holdCnt_d = '0;
                state_d   = EMIT;
            end
            EMIT: begin
                if (holdCnt_q == HOLD_LAST) begin
                    holdCnt_d = '0;
                    if (chipCnt_q == CHIP_LAST) begin
                        state_d   = DONE;
                        memAddr_d = '0;
                        txBit_d   = 1'b0;
                    end else begin
                        chipCnt_d = chipCnt_q + 1'b1;
                        txBit_d   = imem_data[seqSel_q];
                        memAddr_d = satAddr({1'b0, chipCnt_q} + (ADDR_W + 1)'(2));
                    end
                end else begin
                    holdCnt_d = holdCnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef TX_RESTART_EN
        if (istart_trig && (state_q == PREFETCH || state_q == LOAD || state_q == EMIT)) begin
            state_d   = PREFETCH;
            seqSel_d  = isequence_sel;
            chipCnt_d = '0;
            holdCnt_d = '0;
            memAddr_d = '0;
            txBit_d   = 1'b0;
        end
`endif

        // Disable overrides everything, including a pending trigger.
        if (!etx_en) begin
            state_d   = IDLE;
            seqSel_d  = '0;
            chipCnt_d = '0;
            holdCnt_d = '0;
            memAddr_d = '0;
            txBit_d   = 1'b0;
        end
    end

    assign omem_rd_en = (state_q == PREFETCH) || (state_q == LOAD) || (state_q == EMIT);
    assign obusy      = omem_rd_en;
    assign otx_valid  = (state_q == EMIT);
    assign otx_bit    = txBit_q & otx_valid;
    assign odone      = (state_q == DONE);
    assign omem_addr  = memAddr_q;

endmodule

// File: tb/tb_tx_sequence_bits_emitter.sv
// Bench for tx_sequence_bits_emitter: a default instance and a SEQ_LEN=4/CHIP_CYCLES=3 instance checked every cycle
// against a trigger-time arithmetic model; honours TX_RESTART_EN when defined.
module tb_tx_sequence_bits_emitter;

    logic        clk;
    logic        rst;
    logic        en;
    logic        trig1, trig2;
    logic [3:0]  sel1, sel2;
    logic [15:0] memData1, memData2;

    logic        dut1RdEn, dut1Bit, dut1Valid, dut1Busy, dut1Done;
    logic [7:0]  dut1Addr;
    logic        dut2RdEn, dut2Bit, dut2Valid, dut2Busy, dut2Done;
    logic [7:0]  dut2Addr;
    logic [12:0] dut1Outs, dut2Outs;

    assign dut1Outs = {dut1Addr, dut1RdEn, dut1Bit, dut1Valid, dut1Busy, dut1Done};
    assign dut2Outs = {dut2Addr, dut2RdEn, dut2Bit, dut2Valid, dut2Busy, dut2Done};

    tx_sequence_bits_emitter dut1 (
        .ctx_clk(clk), .rtx_rst(rst), .etx_en(en),
        .istart_trig(trig1), .isequence_sel(sel1),
        .omem_rd_en(dut1RdEn), .omem_addr(dut1Addr), .imem_data(memData1),
        .otx_bit(dut1Bit), .otx_valid(dut1Valid), .obusy(dut1Busy), .odone(dut1Done)
    );

    tx_sequence_bits_emitter #(.SEQ_LEN(4), .CHIP_CYCLES(3), .ADDR_W(8)) dut2 (
        .ctx_clk(clk), .rtx_rst(rst), .etx_en(en),
        .istart_trig(trig2), .isequence_sel(sel2),
        .omem_rd_en(dut2RdEn), .omem_addr(dut2Addr), .imem_data(memData2),
        .otx_bit(dut2Bit), .otx_valid(dut2Valid), .obusy(dut2Busy), .odone(dut2Done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: instance 0 uses a*0x9E37, instance 1 the four hand-picked words.
    function automatic logic [15:0] memWord(input int inst, input int a);
        if (inst == 0) begin
            return 16'(a * 32'h9E37);
        end
        case (a)
            0: return 16'h8000;
            1: return 16'h0000;
            2: return 16'hFFFF;
            3: return 16'h8001;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk) begin
        memData1 <= memWord(0, int'(dut1Addr));
        memData2 <= memWord(1, int'(dut2Addr));
    end

    int modelLen[2]    = '{255, 4};
    int modelChip[2]   = '{2, 3};
    bit modelAct[2]    = '{1'b0, 1'b0};
    int modelStart[2]  = '{0, 0};
    int modelSel[2]    = '{0, 0};

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int validCount1 = 0;
    int doneCount1 = 0;
    int lastDone1 = -1;
    int lastRise1 = -1;
    int maxAddr1 = 0;
    bit prevValid1 = 1'b0;
    int lastDone2 = -1;
    bit bits2[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // A sequence accepted at cycle k is described purely by the offset d = now - k.
    function automatic logic [12:0] expOut(input int inst);
        int d, span, n, a;
        logic [15:0] w;
        logic busy, valid, done, b;
        if (!modelAct[inst]) begin
            return '0;
        end
        d     = cyc - modelStart[inst];
        span  = modelLen[inst] * modelChip[inst];
        busy  = (d >= 1) && (d <= 2 + span);
        valid = (d >= 3) && (d <= 2 + span);
        done  = (d == 3 + span);
        a = 0;
        b = 1'b0;
        if (valid) begin
            n = (d - 3) / modelChip[inst];
            a = (n + 1 > modelLen[inst] - 1) ? modelLen[inst] - 1 : n + 1;
            w = memWord(inst, n);
            b = w[modelSel[inst]];
        end
        return {8'(a), busy, b, valid, busy, done};
    endfunction

    task automatic modelStep(input int inst, input logic trig, input logic [3:0] sel);
        int d, span;
        bit canStart;
        d    = cyc - modelStart[inst];
        span = modelLen[inst] * modelChip[inst];
        if (rst || !en) begin
            modelAct[inst] = 1'b0;
        end else begin
            canStart = !modelAct[inst] || (d >= 3 + span);
`ifdef TX_RESTART_EN
            canStart = 1'b1;
`endif
            if (trig && canStart) begin
                modelAct[inst]   = 1'b1;
                modelStart[inst] = cyc;
                modelSel[inst]   = int'(sel);
            end else if (modelAct[inst] && d >= 3 + span) begin
                modelAct[inst] = 1'b0;
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("dut255 outputs", 32'(dut1Outs), 32'(expOut(0)));
        checkOutput("dut4 outputs", 32'(dut2Outs), 32'(expOut(1)));
        if (dut1Valid === 1'b1) begin
            validCount1++;
            if (!prevValid1) lastRise1 = cyc;
        end
        prevValid1 = (dut1Valid === 1'b1);
        if (dut1Done === 1'b1) begin
            doneCount1++;
            lastDone1 = cyc;
        end
        if (int'(dut1Addr) > maxAddr1) maxAddr1 = int'(dut1Addr);
        if (dut2Valid === 1'b1) bits2.push_back(dut2Bit);
        if (dut2Done === 1'b1) lastDone2 = cyc;
    endtask

    // One clock: model consumes the inputs sampled at the edge, outputs compared half a cycle later.
    task automatic tick();
        @(posedge clk);
        modelStep(0, trig1, sel1);
        modelStep(1, trig2, sel2);
        cyc++;
        @(negedge clk);
        compareAll();
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic runUntil(input int target);
        while (cyc < target) tick();
    endtask

    task automatic applyStimulus(input logic t1, input logic [3:0] s1, input logic t2, input logic [3:0] s2);
        trig1 = t1;
        sel1  = s1;
        trig2 = t2;
        sel2  = s2;
        tick();
        trig1 = 1'b0;
        trig2 = 1'b0;
    endtask

    int k, d, t, endAt, doneBase, validBase, bitsBase, action;
    logic [11:0] smallBits;

    initial begin
        rst = 1'b1; en = 1'b0; trig1 = 1'b0; trig2 = 1'b0; sel1 = '0; sel2 = '0;
        runCycles(3);
        checkOutput("reset state", 32'(dut1Outs), 32'h0);
        rst = 1'b0; en = 1'b1;
        runCycles(2);

        // Nominal stream on both instances.
        k = cyc;
        validBase = validCount1; doneBase = doneCount1; bitsBase = bits2.size();
        applyStimulus(1'b1, 4'd5, 1'b1, 4'd15);
        runUntil(k + 3);
        checkOutput("chip0 bit", 32'(dut1Bit), 32'h0);
        checkOutput("chip0 addr", 32'(dut1Addr), 32'h1);
        runUntil(k + 5);
        checkOutput("chip1 bit", 32'(dut1Bit), 32'h1);
        runUntil(k + 15);
        checkOutput("small done", 32'(dut2Done), 32'h1);
        checkOutput("small chip count", bits2.size() - bitsBase, 12);
        smallBits = '0;
        for (int i = 0; i < 12; i++) begin
            if (bitsBase + i < bits2.size()) smallBits = {smallBits[10:0], bits2[bitsBase + i]};
        end
        checkOutput("small chip bits", 32'(smallBits), 32'hE3F);
        runUntil(k + 513);
        checkOutput("nominal done", 32'(dut1Done), 32'h1);
        checkOutput("nominal valid count", validCount1 - validBase, 510);
        checkOutput("nominal done count", doneCount1 - doneBase, 1);

        // Back-to-back trigger in the done cycle.
        d = cyc;
        applyStimulus(1'b1, 4'd3, 1'b0, 4'd0);
        checkOutput("b2b busy", 32'(dut1Busy), 32'h1);
        runUntil(d + 3);
        checkOutput("b2b first valid", lastRise1, d + 3);

        // Trigger while busy at chip 100.
        runUntil(d + 203);
        t = cyc;
        doneBase = doneCount1;
        applyStimulus(1'b1, 4'd9, 1'b0, 4'd0);
`ifdef TX_RESTART_EN
        endAt = t + 513;
`else
        endAt = d + 513;
`endif
        runUntil(endAt);
        checkOutput("busy trig done", 32'(dut1Done), 32'h1);
        checkOutput("busy trig done count", doneCount1 - doneBase, 1);
        runCycles(5);

        // Disable mid-stream, then restart.
        k = cyc;
        applyStimulus(1'b1, 4'd7, 1'b0, 4'd0);
        runUntil(k + 203);
        en = 1'b0;
        doneBase = doneCount1;
        tick();
        en = 1'b1;
        checkOutput("disable outputs", 32'({dut1Addr, dut1Busy, dut1Valid}), 32'h0);
        runCycles(600);
        checkOutput("disable no done", doneCount1 - doneBase, 0);
        k = cyc;
        applyStimulus(1'b1, 4'd2, 1'b0, 4'd0);
        runUntil(k + 3);
        checkOutput("restart after disable", lastRise1, k + 3);
        runUntil(k + 514);

        // Reset held three cycles mid-stream.
        k = cyc;
        applyStimulus(1'b1, 4'd12, 1'b1, 4'd0);
        runUntil(k + 150);
        rst = 1'b1;
        doneBase = doneCount1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("reset hold", 32'(dut1Outs), 32'h0);
        end
        rst = 1'b0;
        runCycles(520);
        checkOutput("reset no done", doneCount1 - doneBase, 0);

        // Randomized triggers, disables and resets.
        for (int it = 0; it < 40; it++) begin
            action = $urandom_range(0, 7);
            case (action)
                0, 1, 2, 3: begin
                    applyStimulus(1'b1, 4'($urandom), 1'($urandom), 4'($urandom));
                    runCycles($urandom_range(1, 600));
                end
                4: begin
                    en = 1'b0;
                    tick();
                    en = 1'b1;
                    runCycles($urandom_range(1, 20));
                end
                5: begin
                    rst = 1'b1;
                    runCycles($urandom_range(1, 3));
                    rst = 1'b0;
                    runCycles($urandom_range(1, 20));
                end
                default: runCycles($urandom_range(1, 40));
            endcase
        end
        runCycles(600);
        checkOutput("max addr", maxAddr1, 254);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
